debug_run_controller: RTL
=========================

# debug_run_controller

Sequencing controller between the debug microcontroller link and the MIPS pipeline. It freezes, runs or single-steps the five-stage pipeline through the pipeline-freeze (`debug_enb`) and step inputs of the stage modules. It detects the HALT instruction and streams a post-mortem dump to the micro: cycle count, register file, then data memory. It drives the debug address/enable inputs that the stage modules currently tie to 0.

## Interface

- `NB_BITS`, 32: datapath and dump word width
- `NB_CMD`, 8: command byte width
- `NB_ADDR`, 5: debug read address width
- `N_REGS`, 32: register-file words dumped; must be ≤ 2^NB_ADDR
- `N_MEM`, 32: data-memory words dumped; must be ≤ 2^NB_ADDR

- `i_clk`  in  1  single clock; all state on rising edge
- `i_rst`  in  1  asynchronous, active-low reset
- `i_cmd`  in  NB_CMD  command byte from micro
- `i_cmd_valid`  in  1  command present
- `o_cmd_ready`  out  1  command accepted on edge where valid&ready
- `i_halt_instr`  in  1  decode holds the HALT opcode this cycle
- `o_debug_enb`  out  1  1 = pipeline frozen (PC and all stage latches hold)
- `o_step`  out  1  one-cycle advance pulse while frozen
- `o_dump_sel`  out  1  0 = register file read port, 1 = data memory read port
- `o_addr_debug`  out  NB_ADDR  debug read address
- `i_data_debug`  in  NB_BITS  read data, valid one cycle after address
- `o_tx_data`  out  NB_BITS  dump word to micro
- `o_tx_valid`  out  1  dump word valid
- `i_tx_ready`  in  1  micro accepts word on edge where valid&ready
- `o_cycle_cnt`  out  32  pipeline-advance cycles since reset
- `o_halted`  out  1  sticky: HALT instruction executed
- `o_state`  out  3  current FSM state encoding, for LEDs

## Operation

- Commands: 0x01 RUN, 0x02 STEP, 0x03 STOP, 0x04 DUMP. Any other byte is accepted and discarded.
- States: IDLE (frozen), RUN, STEP, DUMP_ADDR, DUMP_WAIT, DUMP_SEND.
- Reset values: state IDLE; `o_debug_enb`=1, `o_step`=0, `o_dump_sel`=0, `o_addr_debug`=0, `o_tx_data`=0, `o_tx_valid`=0, `o_cycle_cnt`=0, `o_halted`=0.
- `o_cmd_ready` is combinational: 1 in IDLE and RUN, 0 in all other states.
- IDLE:
  - RUN → RUN; STEP → STEP; DUMP → DUMP_ADDR.
  - RUN and STEP are ignored (stay IDLE) while `o_halted`=1.
  - STOP has no effect.
- RUN:
  - `o_debug_enb`=0.
  - Sampling `i_halt_instr`=1 sets `o_halted` and goes to IDLE.
  - STOP goes to IDLE.
  - Other commands are discarded.
  - Simultaneous STOP and `i_halt_instr`: goes to IDLE with `o_halted` set.
- STEP:
  - `o_step`=1 for exactly one cycle, then IDLE.
  - If `i_halt_instr`=1 during that cycle, `o_halted` is set.
- `o_cycle_cnt` increments on every edge where `o_debug_enb`=0 or `o_step`=1. It wraps modulo 2^32 and never resets except by `i_rst`.
- Dump sequence, pipeline frozen throughout:
  - Word 0 is `o_cycle_cnt` at dump start.
  - Then register file addresses 0..N_REGS-1 with `o_dump_sel`=0.
  - Then data memory addresses 0..N_MEM-1 with `o_dump_sel`=1.
  - Total 1+N_REGS+N_MEM words.
- Per-word state flow:
  - DUMP_ADDR drives the address.
  - DUMP_WAIT waits one read-latency cycle.
  - DUMP_SEND registers `i_data_debug` into `o_tx_data` and asserts `o_tx_valid`.
  - For word 0, DUMP_SEND loads the count snapshot instead of `i_data_debug`, and the read is ignored.
- `o_tx_data` and `o_tx_valid` hold stable until `i_tx_ready`=1.
- After a word is accepted, the address increments. When the register range is exhausted, `o_dump_sel` flips to 1 and the address returns to 0.
- After the last word is accepted: IDLE, `o_addr_debug`=0, `o_dump_sel`=0.

## Timing

- A command accepted at edge k takes effect from cycle k+1:
  - RUN: `o_debug_enb`=0 from k+1.
  - STEP: `o_step`=1 in cycle k+1 only.
  - DUMP: address 0 driven in cycle k+1.
- STOP or HALT sampled at edge m: `o_debug_enb`=1 from m+1. The instruction in decode at m has advanced exactly once.
- Dump throughput is at least 3 cycles per word. With `i_tx_ready` held high, a full default dump takes 65×3 = 195 cycles.
- `o_tx_valid` rises one cycle after DUMP_WAIT and falls the cycle after handshake.
- Asserting `i_rst` at any point (mid-run, mid-step, mid-dump) forces all outputs to their reset values immediately. `o_tx_valid` drops asynchronously and the dump is abandoned.

## Test plan

- **Reset:** hold `i_rst`=0 for 3 cycles, then release → `o_debug_enb`=1, `o_cmd_ready`=1, `o_cycle_cnt`=0, `o_halted`=0.
- **Single step:** STEP three times, with idle cycles between → three single-cycle `o_step` pulses, `o_cycle_cnt`=3, `o_debug_enb` stays 1.
- **Run to HALT:**
  - RUN, then `i_halt_instr`=1 at cycle 20 after acceptance → `o_debug_enb`=1 from the next cycle, `o_halted`=1, `o_cycle_cnt`=20.
  - Subsequent RUN → remains IDLE.
- **Run then STOP:** RUN, STOP after 10 cycles → `o_cycle_cnt`=10. STOP and `i_halt_instr` on the same edge → IDLE with `o_halted`=1.
- **Dump with backpressure:**
  - Model register k = k+0x100 and memory k = k+0x200. Drive `i_tx_ready` with a random 50% pattern.
  - Expect 65 words in order: count, 0x100..0x11F, 0x200..0x21F.
  - `o_tx_data` stable while `o_tx_valid`=1 and `i_tx_ready`=0; `o_cmd_ready`=0 throughout.
- **Reset mid-dump and unknown command:**
  - Assert reset after word 7 → `o_tx_valid`=0 at once; a new DUMP restarts at word 0.
  - Command 0x55 in IDLE → accepted, no state change.

Source files
------------

// File: rtl/debug_run_controller.sv
// Run/step/freeze sequencer for the five-stage pipeline, with a post-mortem dump
// (cycle count, register file, data memory) streamed to the debug micro.
module debug_run_controller #(
    parameter int NB_BITS = 32,
    parameter int NB_CMD  = 8,
    parameter int NB_ADDR = 5,
    parameter int N_REGS  = 32,
    parameter int N_MEM   = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NB_CMD-1:0]  i_cmd,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic               i_halt_instr,
    output logic               o_debug_enb,
    output logic               o_step,
    output logic               o_dump_sel,
    output logic [NB_ADDR-1:0] o_addr_debug,
    input  logic [NB_BITS-1:0] i_data_debug,
    output logic [NB_BITS-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic [31:0]        o_cycle_cnt,
    output logic               o_halted,
    output logic [2:0]         o_state
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_STEP      = 3'd2,
        ST_DUMP_ADDR = 3'd3,
        ST_DUMP_WAIT = 3'd4,
        ST_DUMP_SEND = 3'd5
    } state_t;

    localparam logic [NB_CMD-1:0]  CMD_RUN  = NB_CMD'(1);
    localparam logic [NB_CMD-1:0]  CMD_STEP = NB_CMD'(2);
    localparam logic [NB_CMD-1:0]  CMD_STOP = NB_CMD'(3);
    localparam logic [NB_CMD-1:0]  CMD_DUMP = NB_CMD'(4);
    localparam logic [NB_ADDR-1:0] LAST_REG = NB_ADDR'(N_REGS - 1);
    localparam logic [NB_ADDR-1:0] LAST_MEM = NB_ADDR'(N_MEM - 1);

    state_t               state_q, state_d;
    logic [31:0]          cycle_cnt_q, cycle_cnt_d;
    logic                 halted_q, halted_d;
    logic                 dump_sel_q, dump_sel_d;
    logic [NB_ADDR-1:0]   addr_q, addr_d;
    logic                 hdr_word_q, hdr_word_d;
    logic [NB_BITS-1:0]   tx_data_q, tx_data_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 cmd_fire;

    always_comb begin
        // NOTE: every _d starts from its _q so no branch can leave a signal unassigned and infer a latch.
        state_d     = state_q;
        cycle_cnt_d = cycle_cnt_q;
        halted_d    = halted_q;
        dump_sel_d  = dump_sel_q;
        addr_d      = addr_q;
        hdr_word_d  = hdr_word_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;

        o_cmd_ready = (state_q == ST_IDLE) || (state_q == ST_RUN);
        cmd_fire    = i_cmd_valid && o_cmd_ready;

        if (state_q == ST_RUN || state_q == ST_STEP) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    if (i_cmd == CMD_RUN && !halted_q) begin
                        state_d = ST_RUN;
                    end else if (i_cmd == CMD_STEP && !halted_q) begin
                        state_d = ST_STEP;
                    end else if (i_cmd == CMD_DUMP) begin
                        state_d    = ST_DUMP_ADDR;
                        hdr_word_d = 1'b1;
                        addr_d     = '0;
                        dump_sel_d = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                if (i_halt_instr) begin
                    halted_d = 1'b1;
                    state_d  = ST_IDLE;
                end else if (cmd_fire && i_cmd == CMD_STOP) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: begin
                halted_d = halted_q | i_halt_instr;
                state_d  = ST_IDLE;
            end
            ST_DUMP_ADDR: state_d = ST_DUMP_WAIT;
            ST_DUMP_WAIT: begin
                // The counter is frozen for the whole dump, so its live value is the start snapshot.
                state_d    = ST_DUMP_SEND;
                tx_valid_d = 1'b1;
                tx_data_d  = hdr_word_q ? NB_BITS'(cycle_cnt_q) : i_data_debug;
            end
            ST_DUMP_SEND: begin
                if (i_tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_DUMP_ADDR;
                    if (hdr_word_q) begin
                        hdr_word_d = 1'b0;
                    end else if (!dump_sel_q) begin
                        if (addr_q == LAST_REG) begin
                            dump_sel_d = 1'b1;
                            addr_d     = '0;
                        end else begin
                            addr_d = addr_q + NB_ADDR'(1);
                        end
                    end else if (addr_q == LAST_MEM) begin
                        dump_sel_d = 1'b0;
                        addr_d     = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        addr_d = addr_q + NB_ADDR'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= ST_IDLE;
            cycle_cnt_q <= '0;
            halted_q    <= 1'b0;
            dump_sel_q  <= 1'b0;
            addr_q      <= '0;
            hdr_word_q  <= 1'b0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values regardless of statement order.
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
            halted_q    <= halted_d;
            dump_sel_q  <= dump_sel_d;
            addr_q      <= addr_d;
            hdr_word_q  <= hdr_word_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
        end
    end

    assign o_debug_enb  = (state_q != ST_RUN);
    assign o_step       = (state_q == ST_STEP);
    assign o_dump_sel   = dump_sel_q;
    assign o_addr_debug = addr_q;
    assign o_tx_data    = tx_data_q;
    assign o_tx_valid   = tx_valid_q;
    assign o_cycle_cnt  = cycle_cnt_q;
    assign o_halted     = halted_q;
    assign o_state      = state_q;

endmodule
